alarm_panel: RTL and testbench

Control-panel end of the alarm path: consumes the combined sensor trip line produced by the sensor block and turns it into user-visible behaviour. It runs an arm/disarm state machine with exit delay, entry delay, code-entry lockout and a timed siren, driven by an internal seconds-tick prescaler. It sits in `tt_um_alarm` between the sensor output and the `uo_out` pins; keypad code and arm request arrive on `uio_in`.

---
 rtl/alarm_pkg.sv | 12 +
 rtl/alarm_panel_tick_gen.sv | 20 ++
 rtl/alarm_panel.sv | 102 ++++++++++
 tb/tb_alarm_panel.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared FSM state encoding and counter widths for the alarm panel
package alarm_pkg;
  localparam int DLY_W = 8;
  localparam int FAIL_W = 3;
  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4
  } state_t;
endpackage

// File: rtl/alarm_panel_tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle tick every PRESCALE clocks
module tick_gen #(
  parameter int PRESCALE = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam logic [23:0] LAST = 24'(PRESCALE - 1);
  logic [23:0] cnt;
  // count 0..PRESCALE-1; tick is high the cycle the count has wrapped to zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
      tick <= cnt == LAST;
    end
endmodule

// File: rtl/alarm_panel.sv
// alarm_panel: arm/disarm FSM with exit/entry delays, code lockout and timed siren; ALARM_STROBE_EN pulses the siren per tick
module alarm_panel
  import alarm_pkg::*;
#(
  parameter int         PRESCALE    = 10_000_000,
  parameter int         EXIT_TICKS  = 30,
  parameter int         ENTRY_TICKS = 15,
  parameter int         SIREN_TICKS = 180,
  parameter logic [3:0] CODE        = 4'hA,
  parameter int         MAX_FAILS   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trip,
  input  logic       arm_req,
  input  logic       code_stb,
  input  logic [3:0] code,
  output logic       siren,
  output logic       armed,
  output logic       beep,
  output logic [2:0] state
);
  localparam logic [DLY_W-1:0]  EXIT_L  = DLY_W'(EXIT_TICKS);
  localparam logic [DLY_W-1:0]  ENTRY_L = DLY_W'(ENTRY_TICKS);
  localparam logic [DLY_W-1:0]  SIREN_L = DLY_W'(SIREN_TICKS);
  localparam logic [FAIL_W-1:0] MAX_F   = FAIL_W'(MAX_FAILS);
  logic [1:0] trip_q;
  logic [2:0] arm_q, stb_q;
  logic arm_p, code_p, tick, code_ok, code_bad, expire, enter, siren_keep;
  logic [DLY_W-1:0] dly, dly_n, load_v;
  logic [FAIL_W-1:0] fails, fails_n;
  state_t st, st_n;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));

  assign code_ok  = code_p && code == CODE;
  assign code_bad = code_p && code != CODE;
  assign expire   = tick && dly == DLY_W'(1);
  assign enter    = st_n != st;
  assign state    = st;
  assign load_v   = st_n == ST_EXIT ? EXIT_L : st_n == ST_ENTRY ? ENTRY_L : st_n == ST_ALARM ? SIREN_L : '0;
  assign dly_n    = enter ? load_v : (tick && dly != '0) ? dly - 1'b1 : dly;
`ifdef ALARM_STROBE_EN
  assign siren_keep = tick ? ~siren : siren;
`else
  assign siren_keep = 1'b1;
`endif

  // two-flop synchronizers, then registered rising-edge pulses for button and strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      trip_q <= '0;
      arm_q  <= '0;
      stb_q  <= '0;
      arm_p  <= 1'b0;
      code_p <= 1'b0;
    end else begin
      trip_q <= {trip_q[0], trip};
      arm_q  <= {arm_q[1:0], arm_req};
      stb_q  <= {stb_q[1:0], code_stb};
      arm_p  <= arm_q[1] & ~arm_q[2];
      code_p <= stb_q[1] & ~stb_q[2];
    end

  // next state and fail count; a good code always wins, then fail limit, then expiry, then trip/arm
  always_comb begin
    st_n    = st;
    fails_n = fails;
    case (st)
      ST_DISARMED: st_n = arm_p ? ST_EXIT : st;
      ST_EXIT:     st_n = code_ok ? ST_DISARMED : expire ? ST_ARMED : st;
      ST_ARMED: begin
        st_n    = code_ok ? ST_DISARMED : trip_q[1] ? ST_ENTRY : st;
        fails_n = (!code_ok && trip_q[1]) ? '0 : fails;
      end
      ST_ENTRY: begin
        fails_n = code_bad ? fails + 1'b1 : fails;
        st_n    = code_ok ? ST_DISARMED : ((code_bad && fails_n >= MAX_F) || expire) ? ST_ALARM : st;
      end
      ST_ALARM:    st_n = code_ok ? ST_DISARMED : expire ? ST_ARMED : st;
      default:     st_n = ST_DISARMED;
    endcase
  end

  // state, delay counter and registered outputs; beep and siren restart high on state entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st    <= ST_DISARMED;
      dly   <= '0;
      fails <= '0;
      armed <= 1'b0;
      beep  <= 1'b0;
      siren <= 1'b0;
    end else begin
      st    <= st_n;
      dly   <= dly_n;
      fails <= fails_n;
      armed <= st_n inside {ST_ARMED, ST_ENTRY, ST_ALARM};
      beep  <= (st_n == ST_EXIT || st_n == ST_ENTRY) && (enter || (tick ? ~beep : beep));
      siren <= st_n == ST_ALARM && (enter || siren_keep);
    end
endmodule

// File: tb/tb_alarm_panel.sv
// tb_alarm_panel: directed and random scenarios checked against an elapsed-tick model of the panel
module tb_alarm_panel;
  localparam int P = 4, EXT = 3, ENT = 2, SIR = 5, MF = 3;
  localparam logic [3:0] CV = 4'hA;
  logic clk = 1'b0, rst_n = 1'b0, trip = 1'b0, arm_req = 1'b0, code_stb = 1'b0;
  logic [3:0] code = 4'h0;
  logic siren, armed, beep;
  logic [2:0] state;
  logic [5:0] got;
  int n_tests = 0, n_fail = 0;
  int k, m_st, m_el, m_fails;
  bit h_tr[5], h_ar[5], h_cs[5];

  alarm_panel #(.PRESCALE(P), .EXIT_TICKS(EXT), .ENTRY_TICKS(ENT), .SIREN_TICKS(SIR), .CODE(CV), .MAX_FAILS(MF)) dut (
    .clk(clk), .rst_n(rst_n), .trip(trip), .arm_req(arm_req), .code_stb(code_stb), .code(code),
    .siren(siren), .armed(armed), .beep(beep), .state(state)
  );

  always #5 clk = ~clk;
  assign got = {state, siren, armed, beep};

  function automatic logic [5:0] exp_out();
    logic s, a, b;
    a = m_st >= 2;
    b = (m_st == 1 || m_st == 3) && m_el % 2 == 0;
`ifdef ALARM_STROBE_EN
    s = m_st == 4 && m_el % 2 == 0;
`else
    s = m_st == 4;
`endif
    return {3'(m_st), s, a, b};
  endfunction

  task automatic model_clear();
    k = 0; m_st = 0; m_el = 0; m_fails = 0;
    for (int i = 0; i < 5; i++) begin h_tr[i] = 0; h_ar[i] = 0; h_cs[i] = 0; end
  endtask

  // one clock edge of the panel rules; ticks land every P edges, pins reach the FSM 2 (level) or 3 (edge) edges late
  task automatic model_edge();
    bit tk, ts, ap, ok, bad;
    int nx;
    tk = k > 1 && (k - 1) % P == 0;
    ts = h_tr[2];
    ap = h_ar[3] && !h_ar[4];
    ok = h_cs[3] && !h_cs[4] && code == CV;
    bad = h_cs[3] && !h_cs[4] && code != CV;
    nx = m_st;
    case (m_st)
      0: if (ap) nx = 1;
      1: if (ok) nx = 0; else if (tk && m_el == EXT - 1) nx = 2;
      2: if (ok) nx = 0; else if (ts) begin nx = 3; m_fails = 0; end
      3: begin
        if (ok) nx = 0;
        else if (bad && m_fails + 1 >= MF) nx = 4;
        else if (tk && m_el == ENT - 1) nx = 4;
        if (!ok && bad) m_fails++;
      end
      default: if (ok) nx = 0; else if (tk && m_el == SIR - 1) nx = 2;
    endcase
    if (nx != m_st) m_el = 0; else if (tk) m_el++;
    m_st = nx;
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    for (int i = 4; i > 0; i--) begin h_tr[i] = h_tr[i-1]; h_ar[i] = h_ar[i-1]; h_cs[i] = h_cs[i-1]; end
    h_tr[0] = trip; h_ar[0] = arm_req; h_cs[0] = code_stb;
    model_edge();
    @(negedge clk);
  endtask

  task automatic settle(input int target, input int bound);
    for (int i = 0; i < bound && m_st != target; i++) step();
  endtask

  task automatic pulse_arm();
    arm_req = 1'b1;
    repeat (5) step();
    arm_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    trip = 1'b1;
    n_tests++; if (got !== 6'b0) begin n_fail++; $display("FAIL reset_state got=%h want=%h", got, 6'b0); end
    model_clear();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_tests++; if (got !== exp_out()) begin n_fail++; $display("FAIL reset_release k=%0d got=%h want=%h", k, got, exp_out()); end
    end
    trip = 1'b0;
  endtask

  task automatic test_arm();
    arm_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 2) trip = 1'b1;
      n_tests++; if (state !== (i >= 4 ? 3'd1 : 3'd0)) begin n_fail++; $display("FAIL arm_latency i=%0d got=%0d want=%0d", i, state, i >= 4 ? 1 : 0); end
      n_tests++; if (got !== exp_out()) begin n_fail++; $display("FAIL arm k=%0d got=%h want=%h", k, got, exp_out()); end
    end
    arm_req = 1'b0;
    trip = 1'b0;
    for (int i = 0; i < 40 && m_st != 2; i++) begin
      step();
      n_tests++; if (got !== exp_out()) begin n_fail++; $display("FAIL arm_exit k=%0d got=%h want=%h", k, got, exp_out()); end
    end
    n_tests++; if ({state, armed} !== {3'd2, 1'b1}) begin n_fail++; $display("FAIL armed_reached got=%0d/%b want=2/1", state, armed); end
  endtask

  task automatic test_entry_disarm();
    bit sir_seen = 0;
    trip = 1'b1;
    for (int i = 0; i < 10 && m_st != 3; i++) begin
      step();
      n_tests++; if (got !== exp_out()) begin n_fail++; $display("FAIL entry k=%0d got=%h want=%h", k, got, exp_out()); end
    end
    n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL entry_reached got=%0d want=3", state); end
    code = CV; code_stb = 1'b1; trip = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 5) code_stb = 1'b0;
      sir_seen |= siren;
      n_tests++; if (got !== exp_out()) begin n_fail++; $display("FAIL entry_disarm k=%0d got=%h want=%h", k, got, exp_out()); end
    end
    n_tests++; if ({state, armed, sir_seen} !== 5'b0) begin n_fail++; $display("FAIL disarmed_in_entry got=%0d/%b/%b want=0/0/0", state, armed, sir_seen); end
  endtask

  task automatic test_wrong_codes();
    pulse_arm();
    settle(2, 60);
    n_tests++; if (state !== 3'd2) begin n_fail++; $display("FAIL rearm got=%0d want=2", state); end
    for (int i = 0; i < 4 && k % 4 != 2; i++) step();
    trip = 1'b1; code = 4'h3;
    for (int j = 0; j < 9; j++) begin
      code_stb = j < 6 && j % 2 == 0;
      step();
      n_tests++; if (got !== exp_out()) begin n_fail++; $display("FAIL wrong_codes k=%0d got=%h want=%h", k, got, exp_out()); end
      if (j == 6) begin n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL two_bad_codes got=%0d want=3", state); end end
      if (j == 7) begin n_tests++; if ({state, siren} !== {3'd4, 1'b1}) begin n_fail++; $display("FAIL fail_limit got=%0d/%b want=4/1", state, siren); end end
    end
  endtask

  task automatic test_reset_mid_alarm();
    n_tests++; if (state !== 3'd4) begin n_fail++; $display("FAIL pre_reset_alarm got=%0d want=4", state); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (got !== 6'b0) begin n_fail++; $display("FAIL reset_mid_alarm got=%h want=%h", got, 6'b0); end
    @(negedge clk); @(negedge clk);
    model_clear();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      n_tests++; if (got !== exp_out()) begin n_fail++; $display("FAIL after_reset k=%0d got=%h want=%h", k, got, exp_out()); end
    end
    trip = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_siren_timeout();
    int al = 0;
    pulse_arm();
    settle(2, 60);
    trip = 1'b1;
    settle(3, 10);
    trip = 1'b0;
    for (int i = 0; i < 60 && !(m_st == 2 && al > 0); i++) begin
      step();
      if (state === 3'd4) al++;
      n_tests++; if (got !== exp_out()) begin n_fail++; $display("FAIL siren_timeout k=%0d got=%h want=%h", k, got, exp_out()); end
    end
    n_tests++; if ({state, siren} !== {3'd2, 1'b0}) begin n_fail++; $display("FAIL rearm_after_siren got=%0d/%b want=2/0", state, siren); end
    n_tests++; if (al < P * (SIR - 1) + 1 || al > P * SIR) begin n_fail++; $display("FAIL alarm_length got=%0d want=%0d..%0d", al, P * (SIR - 1) + 1, P * SIR); end
  endtask

  task automatic test_simultaneous();
    int t, e;
    bit al_seen = 0;
    if (m_st == 0) pulse_arm();
    settle(2, 60);
    trip = 1'b1;
    settle(3, 10);
    trip = 1'b0;
    t = k + 1;
    while ((t - 1) % P != 0) t++;
    e = t + P * (ENT - 1);
    while (k < e - 4) step();
    code = CV; code_stb = 1'b1;
    while (k < e) begin
      step();
      al_seen |= state === 3'd4;
      n_tests++; if (got !== exp_out()) begin n_fail++; $display("FAIL simultaneous k=%0d got=%h want=%h", k, got, exp_out()); end
    end
    n_tests++; if ({state, al_seen} !== 4'b0) begin n_fail++; $display("FAIL code_beats_expiry got=%0d/%b want=0/0", state, al_seen); end
    repeat (3) step();
    code_stb = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_random();
    int lowc = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) trip = ~trip;
      if ($urandom_range(0, 39) == 0) arm_req = 1'b1; else if ($urandom_range(0, 3) == 0) arm_req = 1'b0;
      if (code_stb) begin
        if ($urandom_range(0, 2) == 0) code_stb = 1'b0;
        lowc = 0;
      end else begin
        lowc++;
        if (lowc >= 5 && $urandom_range(0, 15) == 0) begin
          code = $urandom_range(0, 2) == 0 ? CV : 4'($urandom_range(0, 15));
          code_stb = 1'b1;
        end
      end
      step();
      n_tests++; if (got !== exp_out()) begin n_fail++; $display("FAIL random k=%0d got=%h want=%h", k, got, exp_out()); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_arm();
    test_entry_disarm();
    test_wrong_codes();
    test_reset_mid_alarm();
    test_siren_timeout();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
